// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter: round-robin grant between valid/ready ports,
// then a tick-paced 8N1-style frame (start, data LSB-first, stop) on tx.
module uart_tx_arbiter #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              tx,
  output logic              busy,
  output logic              grant_id,
  output logic              frame_done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;
  logic              grant_id_q, grant_id_d;
  logic              frame_done_q, frame_done_d;

  logic any_valid;
  logic winner;
  logic can_accept;

  // Handshake: a byte moves when reqK_valid && reqK_ready; ready is a pure
  // function of registered state and the current valids, never of data.
  // The frame_done cycle still belongs to the finished frame, so no grant then.
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    winner     = (req0_valid && req1_valid) ? rr_q : req1_valid;
    can_accept = (state_q == IDLE) && !frame_done_q && any_valid;
  end

  assign req0_ready = can_accept && !winner;
  assign req1_ready = can_accept && winner;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    tx_d         = tx_q;
    grant_id_d   = grant_id_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (can_accept) begin
          shift_d    = winner ? req1_data : req0_data;
          grant_id_d = winner;
          state_d    = SYNC;
        end
      end
      // Waiting for a tick here keeps the start bit a full bit period wide.
      SYNC: begin
        if (tick) begin
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
            rr_d         = ~grant_id_q;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      tx_q         <= 1'b1;
      grant_id_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      tx_q         <= tx_d;
      grant_id_q   <= grant_id_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || frame_done_q;
  assign grant_id   = grant_id_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (1 and 2 stop bits) checked every
// cycle against a frame-segment model, plus directed literal expectations.
module tb_uart_tx_arbiter;

  localparam int DW    = 8;
  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  logic r0_valid = 1'b0, r1_valid = 1'b0, s0_valid = 1'b0, s1_valid = 1'b0;
  logic [DW-1:0] r0_data = '0, r1_data = '0, s0_data = '0, s1_data = '0;
  logic d_rdy0, d_rdy1, d_tx, d_busy, d_gid, d_done;
  logic e_rdy0, e_rdy1, e_tx, e_busy, e_gid, e_done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tcnt = 0;
  bit chk_en = 1'b0;
  int done_cnt[2] = '{0, 0};
  logic [0:0] got_q[$];
  logic [0:0] exp_q[$];
  int t1_seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  uart_tx_arbiter #(.DATA_W(DW), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .req0_valid(r0_valid), .req0_data(r0_data), .req0_ready(d_rdy0),
    .req1_valid(r1_valid), .req1_data(r1_data), .req1_ready(d_rdy1),
    .tx(d_tx), .busy(d_busy), .grant_id(d_gid), .frame_done(d_done)
  );

  uart_tx_arbiter #(.DATA_W(DW), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tick(tick),
    .req0_valid(s0_valid), .req0_data(s0_data), .req0_ready(e_rdy0),
    .req1_valid(s1_valid), .req1_data(s1_data), .req1_ready(e_rdy1),
    .tx(e_tx), .busy(e_busy), .grant_id(e_gid), .frame_done(e_done)
  );

  logic vld_a[2][2];
  logic [DW-1:0] dat_a[2][2];
  logic rdy_a[2][2];
  logic tx_a[2], busy_a[2], gid_a[2], done_a[2];

  assign vld_a[0][0] = r0_valid;
  assign vld_a[0][1] = r1_valid;
  assign vld_a[1][0] = s0_valid;
  assign vld_a[1][1] = s1_valid;
  assign dat_a[0][0] = r0_data;
  assign dat_a[0][1] = r1_data;
  assign dat_a[1][0] = s0_data;
  assign dat_a[1][1] = s1_data;
  assign rdy_a[0][0] = d_rdy0;
  assign rdy_a[0][1] = d_rdy1;
  assign rdy_a[1][0] = e_rdy0;
  assign rdy_a[1][1] = e_rdy1;
  assign tx_a[0] = d_tx;
  assign tx_a[1] = e_tx;
  assign busy_a[0] = d_busy;
  assign busy_a[1] = e_busy;
  assign gid_a[0] = d_gid;
  assign gid_a[1] = e_gid;
  assign done_a[0] = d_done;
  assign done_a[1] = e_done;

  // ---------------- clock / tick / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick = (tcnt == 15);
      tcnt = (tcnt + 1) % 16;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  // A frame is a list of line segments: 0 = wait-for-tick (high), 1 = start,
  // 2..DW+1 = data LSB first, then STOP_BITS stop segments. Each tick moves on.
  logic m_act[2], m_done[2], m_rr[2], m_gid[2];
  int m_seg[2];
  logic [DW-1:0] m_byte[2];

  function automatic int last_seg(input int i);
    return 1 + DW + ((i == 0) ? 1 : 2);
  endfunction

  function automatic logic seg_level(input logic [DW-1:0] b, input int seg);
    if (seg == 1) return 1'b0;
    if (seg >= 2 && seg < 2 + DW) return b[seg-2];
    return 1'b1;
  endfunction

  function automatic int winner(input logic v0, input logic v1, input logic rr);
    if (v0 && v1) return rr ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int w;
    logic dn;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 1'b0;
        m_done[i] = 1'b0;
        m_rr[i] = 1'b0;
        m_gid[i] = 1'b0;
        m_seg[i] = 0;
        m_byte[i] = '0;
      end else begin
        dn = 1'b0;
        if (!m_act[i]) begin
          if (!m_done[i]) begin
            w = winner(vld_a[i][0], vld_a[i][1], m_rr[i]);
            if (w >= 0) begin
              m_act[i] = 1'b1;
              m_seg[i] = 0;
              m_byte[i] = dat_a[i][w];
              m_gid[i] = (w == 1);
            end
          end
        end else if (tick) begin
          if (m_seg[i] == last_seg(i)) begin
            m_act[i] = 1'b0;
            dn = 1'b1;
            m_rr[i] = ~m_gid[i];
          end else begin
            m_seg[i] = m_seg[i] + 1;
          end
        end
        m_done[i] = dn;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int w;
    logic etx, ebusy;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        etx = m_act[i] ? seg_level(m_byte[i], m_seg[i]) : 1'b1;
        ebusy = m_act[i] || m_done[i];
        w = ebusy ? -1 : winner(vld_a[i][0], vld_a[i][1], m_rr[i]);
        chk($sformatf("i%0d_tx", i), tx_a[i], etx);
        chk($sformatf("i%0d_busy", i), busy_a[i], ebusy);
        chk($sformatf("i%0d_grant_id", i), gid_a[i], m_gid[i]);
        chk($sformatf("i%0d_frame_done", i), done_a[i], m_done[i]);
        chk($sformatf("i%0d_ready0", i), rdy_a[i][0], (w == 0));
        chk($sformatf("i%0d_ready1", i), rdy_a[i][1], (w == 1));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (r0_valid && d_rdy0) got_q.push_back(1'b0);
      if (r1_valid && d_rdy1) got_q.push_back(1'b1);
      for (int i = 0; i < 2; i++) if (done_a[i] === 1'b1) done_cnt[i]++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic at_pos();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    at_pos();
    r0_valid = 1'b0; r1_valid = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
    rst = 1'b1;
    repeat (2) at_pos();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int inst, input int k, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(vld_a[inst][k] && rdy_a[inst][k]) && n < LIMIT);
    chk({nm, "_accept_in_time"}, (n < LIMIT), 1);
  endtask

  task automatic wait_any_accept(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!((r0_valid && d_rdy0) || (r1_valid && d_rdy1)) && n < LIMIT);
    chk({nm, "_accept_in_time"}, (n < LIMIT), 1);
  endtask

  task automatic wait_tx(input int inst, input logic lvl, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (tx_a[inst] !== lvl && n < LIMIT);
    chk($sformatf("i%0d_tx_level_in_time", inst), (n < LIMIT), 1);
  endtask

  task automatic wait_done(input int inst, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (done_a[inst] !== 1'b1 && n < LIMIT);
    chk($sformatf("i%0d_done_in_time", inst), (n < LIMIT), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy_a[0] || busy_a[1]) && n < LIMIT);
    chk("idle_in_time", (n < LIMIT), 1);
    repeat (2) at_pos();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n, dc, ac;
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("reset_tx", d_tx, 1);
    chk("reset_busy", d_busy, 0);
    chk("reset_grant_id", d_gid, 0);
    chk("reset_frame_done", d_done, 0);
    at_pos();
    rst = 1'b0;

    // 1: single byte 0xA5 from requester 0
    at_pos();
    r0_data = 8'hA5; r0_valid = 1'b1;
    wait_ready(0, 0, "t1");
    @(negedge clk);
    chk("t1_ready_one_clk", d_rdy0, 0);
    at_pos();
    r0_valid = 1'b0; r0_data = 8'h00;
    wait_tx(0, 1'b0, n);
    repeat (8) @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      chk($sformatf("t1_bit%0d", b), d_tx, t1_seq[b]);
      if (b < 9) repeat (16) @(negedge clk);
    end
    wait_done(0, n);
    chk("t1_frame_len", 152 + n, 160);
    chk("t1_grant_id", d_gid, 0);
    wait_idle();
    chk("t1_done_pulses", done_cnt[0], 1);

    // 2: both valid from reset
    do_reset();
    r0_data = 8'h55; r1_data = 8'h0F; r0_valid = 1'b1; r1_valid = 1'b1;
    wait_ready(0, 0, "t2_r0");
    at_pos();
    r0_valid = 1'b0;
    wait_done(0, n);
    dc = cyc;
    wait_ready(0, 1, "t2_r1");
    ac = cyc;
    chk("t2_accept_after_done", (ac > dc), 1);
    at_pos();
    r1_valid = 1'b0;
    @(negedge clk);
    chk("t2_grant_id", d_gid, 1);
    wait_idle();

    // 3: both valid for four frames
    got_q.delete();
    exp_q.delete();
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    at_pos();
    r0_data = 8'h3C; r1_data = 8'hC3; r0_valid = 1'b1; r1_valid = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_any_accept($sformatf("t3_f%0d", f));
      at_pos();
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    wait_idle();
    chk("t3_grant_count", got_q.size(), 4);
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk("t3_grant_seq", got_q.pop_front(), exp_q.pop_front());
    r1_data = 8'h81; r1_valid = 1'b1;
    @(negedge clk);
    chk("t3_r1_alone_wins", d_rdy1, 1);
    at_pos();
    r1_valid = 1'b0;
    wait_done(0, n);
    wait_idle();

    // 4: two stop bits, byte 0xFF
    done_cnt[1] = 0;
    s0_data = 8'hFF; s0_valid = 1'b1;
    wait_ready(1, 0, "t4");
    at_pos();
    s0_valid = 1'b0;
    wait_tx(1, 1'b0, n);
    wait_done(1, n);
    chk("t4_start_to_done", n, 176);
    wait_idle();
    chk("t4_done_pulses", done_cnt[1], 1);

    // 5: reset during data bit 3
    r0_data = 8'h11; r0_valid = 1'b1;
    wait_ready(0, 0, "t5_pre");
    at_pos();
    r0_valid = 1'b0;
    wait_done(0, n);
    wait_idle();
    r1_data = 8'h37; r1_valid = 1'b1;
    wait_ready(0, 1, "t5_victim");
    at_pos();
    r1_valid = 1'b0;
    wait_tx(0, 1'b0, n);
    repeat (70) @(negedge clk);
    chk("t5_tx_bit3_low", d_tx, 0);
    done_cnt[0] = 0;
    at_pos();
    rst = 1'b1;
    #1;
    chk("t5_async_tx", d_tx, 1);
    chk("t5_async_busy", d_busy, 0);
    repeat (2) at_pos();
    got_q.delete();
    rst = 1'b0;
    r0_data = 8'h44; r1_data = 8'h22; r0_valid = 1'b1; r1_valid = 1'b1;
    wait_any_accept("t5_after");
    at_pos();
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk("t5_first_grant_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("t5_first_grant_r0", got_q[0], 0);
    chk("t5_no_done_from_abort", done_cnt[0], 0);
    wait_done(0, n);
    wait_idle();

    // 6: tick in the acceptance cycle is ignored
    n = 0;
    do begin at_pos(); n++; end while (tick !== 1'b1 && n < 40);
    chk("t6_tick_found", (n < 40), 1);
    r0_data = 8'h5B; r0_valid = 1'b1;
    @(negedge clk);
    chk("t6_ready_on_tick", d_rdy0, 1);
    at_pos();
    r0_valid = 1'b0;
    wait_tx(0, 1'b0, n);
    chk("t6_start_delay", n, 17);
    wait_tx(0, 1'b1, n);
    chk("t6_start_width", n, 16);
    wait_done(0, n);
    wait_idle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
